// File: rtl/dm_port_arbiter_if.sv
// Bundle of the two pipeline data-memory ports and the shared RAM port
// seen by dm_port_arbiter. The slave modport is the arbiter's view. The
// master modport is the environment's view: the two pipelines plus the
// RAM read-data return.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_stall;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_stall;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_stall, p0_rvalid, p0_rdata,
    output p1_stall, p1_rvalid, p1_rdata,
    output mem_addr, mem_wdata, mem_write
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_stall, p0_rvalid, p0_rdata,
    input  p1_stall, p1_rvalid, p1_rdata,
    input  mem_addr, mem_wdata, mem_write
  );

endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one single-port synchronous data RAM between
// pipelines p0 and p1.
// - At most one access is granted per cycle; the losing port sees stall.
// - Read data returns one cycle after the grant. In that cycle it is passed
//   straight through from the RAM and also captured into a per-port hold
//   register, so rdata keeps showing the last read value afterwards.
// - FIXED_PRIO = 0 selects round-robin; FIXED_PRIO = 1 lets p1 always win.
// Optional feature, guarded by the macro DM_ARB_READ_SHARE_EN:
//   When both ports read the same address in the same cycle, both are
//   granted together and neither stalls. The round-robin pointer is not
//   moved in that case.
module dm_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  // last_grant: 0 = p0 won the most recent grant, 1 = p1 won it.
  logic              last_grant_q, last_grant_d;
  logic [1:0]        rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;

  logic share;
  logic gnt0, gnt1;

`ifdef DM_ARB_READ_SHARE_EN
  // Two reads of the same word can be served by a single RAM access.
  always_comb begin
    share = bus.p0_req & bus.p1_req & ~bus.p0_we & ~bus.p1_we &
            (bus.p0_addr == bus.p1_addr);
  end
`else
  // Without read sharing, every conflict goes through normal arbitration.
  always_comb begin
    share = 1'b0;
  end
`endif

  // Grant selection. While reset is high nothing is granted, so the RAM
  // never sees a write during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (share) begin
        gnt0 = 1'b1;
        gnt1 = 1'b1;
      end else if (bus.p0_req && bus.p1_req) begin
        if (FIXED_PRIO != 0) begin
          gnt1 = 1'b1;
        end else if (last_grant_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  // Stall each port that is requesting this cycle but was not granted.
  always_comb begin
    bus.p0_stall = bus.p0_req & ~gnt0;
    bus.p1_stall = bus.p1_req & ~gnt1;
  end

  // Steer the granted port onto the RAM. When idle, drive zeros. In the
  // shared-read case both addresses are equal and neither is a write, so
  // picking p1 is harmless.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_write = 1'b0;
    if (gnt1) begin
      bus.mem_addr  = bus.p1_addr;
      bus.mem_wdata = bus.p1_wdata;
      bus.mem_write = bus.p1_we;
    end else if (gnt0) begin
      bus.mem_addr  = bus.p0_addr;
      bus.mem_wdata = bus.p0_wdata;
      bus.mem_write = bus.p0_we;
    end
  end

  // Next state:
  // - Move the round-robin pointer on every real grant (not on a shared read).
  // - Flag granted reads as pending for exactly the next cycle.
  // - Capture the returning read data into the hold registers.
  always_comb begin
    last_grant_d = last_grant_q;
    if (!share && (gnt0 || gnt1)) begin
      last_grant_d = gnt1;
    end
    rd_pend_d = {gnt1 & ~bus.p1_we, gnt0 & ~bus.p0_we};
    hold0_d   = rd_pend_q[0] ? bus.mem_rdata : hold0_q;
    hold1_d   = rd_pend_q[1] ? bus.mem_rdata : hold1_q;
  end

  // State registers. Reset clears pending reads so no rvalid can appear
  // after reset, and the pointer starts at p1 so p0 wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 2'b00;
      hold0_q      <= '0;
      hold1_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      hold0_q      <= hold0_d;
      hold1_q      <= hold1_d;
    end
  end

  // Read return: pass the RAM data through in the cycle after the grant;
  // otherwise show the last value read.
  always_comb begin
    bus.p0_rvalid = rd_pend_q[0];
    bus.p1_rvalid = rd_pend_q[1];
    bus.p0_rdata  = rd_pend_q[0] ? bus.mem_rdata : hold0_q;
    bus.p1_rdata  = rd_pend_q[1] ? bus.mem_rdata : hold1_q;
  end

endmodule
